// File: rtl/seq_detector_param_pkg.sv
// Shared defaults, legal parameter ranges and helpers for the parametrised serial-pattern detector.
package seq_detector_param_pkg;

  localparam int unsigned PAT_W_MIN   = 2;
  localparam int unsigned PAT_W_MAX   = 32;
  localparam int unsigned DEF_PAT_W   = 5;
  localparam int unsigned DEF_CNT_W   = 8;
  localparam logic [31:0] DEF_PATTERN = 32'h0000_001D;

  // Per-edge operation selected by the control inputs, in priority order.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'd0,
    OP_LOAD  = 2'd1,
    OP_SHIFT = 2'd2
  } op_e;

  function automatic logic pat_w_ok(input int unsigned w);
    return (w >= PAT_W_MIN) && (w <= PAT_W_MAX);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] q_r;
  logic [W-1:0] q_s;

  // next count: clear, saturating increment, or hold
  always_comb begin
    q_s = q_r;
    if (clr) begin
      q_s = {W{1'b0}};
    end else if (inc && (q_r != {W{1'b1}})) begin
      q_s = q_r + W'(1'b1);
    end else begin
      q_s = q_r;
    end
  end

  // count register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_r <= {W{1'b0}};
    end else begin
      q_r <= q_s;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/seq_detector_param.sv
// Moore serial-pattern detector: shift window, fill gate, reloadable pattern and a saturating match count.
module seq_detector_param
  import seq_detector_param_pkg::*;
#(
  parameter int unsigned      PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN[PAT_W-1:0],
  parameter bit               OVERLAP = 1'b1,
  parameter int unsigned      CNT_W   = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             datain,
  input  logic             din_valid,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             count_clear,
  output logic             dataout,
  output logic [CNT_W-1:0] match_count
);

  localparam int unsigned     FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_ONE  = {{(FILL_W-1){1'b0}}, 1'b1};

  if (!pat_w_ok(PAT_W)) begin : g_bad_pat_w
    $error("seq_detector_param: PAT_W out of range 2..32");
  end

  // The oldest window bit is never needed again once shifted, so only PAT_W-1 bits are kept.
  logic [PAT_W-2:0]  hist_r, hist_s;
  logic [PAT_W-1:0]  pattern_r, pattern_s;
  logic [PAT_W-1:0]  win_s;
  logic [FILL_W-1:0] fill_r, fill_s, nf_s;
  logic              dataout_r, dataout_s;
  logic              hit_s;
  op_e               op_s;

  // operation decode: load beats shift beats idle
  always_comb begin
    op_s = OP_IDLE;
    if (pat_load) begin
      op_s = OP_LOAD;
    end else if (din_valid) begin
      op_s = OP_SHIFT;
    end else begin
      op_s = OP_IDLE;
    end
  end

  // window and compare
  always_comb begin
    win_s = {hist_r, datain};
    nf_s  = (fill_r == FILL_FULL) ? FILL_FULL : (fill_r + FILL_ONE);
    hit_s = (op_s == OP_SHIFT) && (nf_s == FILL_FULL) && (win_s == pattern_r);
  end

  // next-state logic
  always_comb begin
    hist_s    = hist_r;
    fill_s    = fill_r;
    pattern_s = pattern_r;
    dataout_s = dataout_r;
    case (op_s)
      OP_LOAD: begin
        pattern_s = pat_in;
        hist_s    = {(PAT_W-1){1'b0}};
        fill_s    = {FILL_W{1'b0}};
        dataout_s = 1'b0;
      end
      OP_SHIFT: begin
        hist_s    = win_s[PAT_W-2:0];
        dataout_s = hit_s;
        if (hit_s && !OVERLAP) begin
          fill_s = {FILL_W{1'b0}};
        end else begin
          fill_s = nf_s;
        end
      end
      OP_IDLE: begin
        hist_s    = hist_r;
        fill_s    = fill_r;
        pattern_s = pattern_r;
        dataout_s = dataout_r;
      end
      default: begin
        hist_s    = hist_r;
        fill_s    = fill_r;
        pattern_s = pattern_r;
        dataout_s = dataout_r;
      end
    endcase
  end

  // state registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hist_r    <= {(PAT_W-1){1'b0}};
      fill_r    <= {FILL_W{1'b0}};
      pattern_r <= PATTERN;
      dataout_r <= 1'b0;
    end else begin
      hist_r    <= hist_s;
      fill_r    <= fill_s;
      pattern_r <= pattern_s;
      dataout_r <= dataout_s;
    end
  end

  assign dataout = dataout_r;

  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (hit_s),
    .clr   (count_clear),
    .q     (match_count)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench: overlap and non-overlap detectors on a shared stream, plus a 2-bit-counter all-ones detector.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       din, dv, pl, cc;
  logic [4:0] pi;
  logic       din2, dv2, cc2;

  logic       a_out, b_out, c_out;
  logic [7:0] a_cnt, b_cnt;
  logic [1:0] c_cnt;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  seq_detector_param u_dut_a (
    .clock(clk), .reset(rst), .datain(din), .din_valid(dv), .pat_load(pl),
    .pat_in(pi), .count_clear(cc), .dataout(a_out), .match_count(a_cnt)
  );

  seq_detector_param #(.OVERLAP(1'b0)) u_dut_b (
    .clock(clk), .reset(rst), .datain(din), .din_valid(dv), .pat_load(pl),
    .pat_in(pi), .count_clear(cc), .dataout(b_out), .match_count(b_cnt)
  );

  seq_detector_param #(.PATTERN(5'b11111), .CNT_W(2)) u_dut_c (
    .clock(clk), .reset(rst), .datain(din2), .din_valid(dv2), .pat_load(1'b0),
    .pat_in(5'b00000), .count_clear(cc2), .dataout(c_out), .match_count(c_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one accepted bit on the shared stream
  task automatic send(input logic b);
    dv = 1'b1; din = b;
    @(posedge clk); #1;
    dv = 1'b0; din = 1'b0;
  endtask

  task automatic send_seq(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) send(bits[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic load(input logic [4:0] p);
    pl = 1'b1; pi = p; dv = 1'b1; din = 1'b1;
    @(posedge clk); #1;
    pl = 1'b0; dv = 1'b0; din = 1'b0;
  endtask

  task automatic send_c(input logic b, input logic clr);
    dv2 = 1'b1; din2 = b; cc2 = clr;
    @(posedge clk); #1;
    dv2 = 1'b0; din2 = 1'b0; cc2 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; din = 1'b0; dv = 1'b0; pl = 1'b0; cc = 1'b0; pi = 5'b00000;
    din2 = 1'b0; dv2 = 1'b0; cc2 = 1'b0;
    idle(2);
    chk("reset_out_a", {31'd0, a_out}, 32'd0);
    chk("reset_cnt_a", {24'd0, a_cnt}, 32'd0);
    chk("reset_cnt_c", {30'd0, c_cnt}, 32'd0);
    rst = 1'b0;
    idle(1);

    // first match of 11101
    send_seq(16'b1110, 4);
    chk("partial_a", {31'd0, a_out}, 32'd0);
    send(1'b1);
    chk("match1_out_a", {31'd0, a_out}, 32'd1);
    chk("match1_cnt_a", {24'd0, a_cnt}, 32'd1);
    chk("match1_out_b", {31'd0, b_out}, 32'd1);

    // overlapping continuation 1,1,0,1
    send_seq(16'b110, 3);
    chk("ovl_mid_a", {31'd0, a_out}, 32'd0);
    send(1'b1);
    chk("ovl_out_a", {31'd0, a_out}, 32'd1);
    chk("ovl_cnt_a", {24'd0, a_cnt}, 32'd2);
    chk("novl_out_b", {31'd0, b_out}, 32'd0);
    chk("novl_cnt_b", {24'd0, b_cnt}, 32'd1);

    // idle holds a set flag, then zeros clear it
    idle(3);
    chk("hold1_out_a", {31'd0, a_out}, 32'd1);
    chk("hold1_cnt_a", {24'd0, a_cnt}, 32'd2);
    send(1'b0);
    chk("zero1_out_a", {31'd0, a_out}, 32'd0);
    send(1'b0);
    idle(3);
    chk("hold0_out_a", {31'd0, a_out}, 32'd0);
    chk("hold0_cnt_a", {24'd0, a_cnt}, 32'd2);

    // match, then load all-zero pattern: flag drops and the fill gate blocks early matches
    send_seq(16'b11101, 5);
    chk("match3_cnt_a", {24'd0, a_cnt}, 32'd3);
    load(5'b00000);
    chk("load_out_a", {31'd0, a_out}, 32'd0);
    chk("load_cnt_a", {24'd0, a_cnt}, 32'd3);
    send_seq(16'b0000, 4);
    chk("zpat_gate_a", {31'd0, a_out}, 32'd0);
    send(1'b0);
    chk("zpat_out_a", {31'd0, a_out}, 32'd1);
    chk("zpat_cnt_a", {24'd0, a_cnt}, 32'd4);

    // reload during a partial match
    send(1'b1);
    load(5'b10110);
    chk("reload_out_a", {31'd0, a_out}, 32'd0);
    send_seq(16'b1011, 4);
    chk("newpat_mid_a", {31'd0, a_out}, 32'd0);
    send(1'b0);
    chk("newpat_out_a", {31'd0, a_out}, 32'd1);
    chk("newpat_cnt_a", {24'd0, a_cnt}, 32'd5);
    send_seq(16'b11101, 5);
    chk("oldpat_out_a", {31'd0, a_out}, 32'd0);
    chk("oldpat_cnt_a", {24'd0, a_cnt}, 32'd5);

    // async reset mid-pattern loses progress and restores the default pattern
    send_seq(16'b111, 3);
    #2 rst = 1'b1;
    #1;
    chk("arst_cnt_a", {24'd0, a_cnt}, 32'd0);
    chk("arst_out_a", {31'd0, a_out}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    send_seq(16'b01, 2);
    chk("post_rst_a", {31'd0, a_out}, 32'd0);
    send_seq(16'b1110, 4);
    chk("post_rst_mid_a", {31'd0, a_out}, 32'd0);
    send(1'b1);
    chk("post_rst_out_a", {31'd0, a_out}, 32'd1);
    chk("post_rst_cnt_a", {24'd0, a_cnt}, 32'd1);

    // clear coincident with an overlapping hit
    send_seq(16'b110, 3);
    cc = 1'b1;
    send(1'b1);
    cc = 1'b0;
    chk("clr_hit_out_a", {31'd0, a_out}, 32'd1);
    chk("clr_hit_cnt_a", {24'd0, a_cnt}, 32'd0);

    // 2-bit counter saturation on a run of ones
    for (int i = 0; i < 4; i++) send_c(1'b1, 1'b0);
    chk("c_gate", {31'd0, c_out}, 32'd0);
    send_c(1'b1, 1'b0);
    chk("c_m1_out", {31'd0, c_out}, 32'd1);
    chk("c_m1_cnt", {30'd0, c_cnt}, 32'd1);
    send_c(1'b1, 1'b0);
    send_c(1'b1, 1'b0);
    chk("c_m3_cnt", {30'd0, c_cnt}, 32'd3);
    send_c(1'b1, 1'b0);
    chk("c_sat4_cnt", {30'd0, c_cnt}, 32'd3);
    send_c(1'b1, 1'b0);
    chk("c_sat5_cnt", {30'd0, c_cnt}, 32'd3);
    send_c(1'b1, 1'b1);
    chk("c_clr_out", {31'd0, c_out}, 32'd1);
    chk("c_clr_cnt", {30'd0, c_cnt}, 32'd0);
    send_c(1'b1, 1'b0);
    chk("c_after_clr", {30'd0, c_cnt}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
